fwd_scoreboard: RTL
===================

Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit for the MIPS pipeline.
- Tracks every in-flight register write from EX to WB in an internal shift-register scoreboard.
- Supplies bypassed operands to NUM_RD decode read ports and raises a load-use stall when an operand is not yet produced.
- Drives the register-file write port from its final stage. It replaces per-operand combinational bypass muxes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width; register 0 is hardwired zero.
- NUM_RD, 2, number of decode read ports.
- DEPTH, 3, tracked stages after decode (0=EX … DEPTH-1=WB); must be ≥ LOAD_STAGE+2.
- LOAD_STAGE, 1, stage index whose output carries load data (mem_result).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  downstream freeze; the scoreboard does not shift.
- flush  in  1  discard the instruction currently in decode (branch redirect).
- iss_valid  in  1  decode holds a valid instruction.
- iss_we  in  1  instruction writes a register.
- iss_load  in  1  instruction is a load.
- iss_dst  in  REG_AW  destination register.
- rs_addr  in  NUM_RD*REG_AW  source register per port, port i at bits [i*REG_AW +: REG_AW].
- rf_data  in  NUM_RD*DATA_W  register-file read data per port.
- ex_result  in  DATA_W  ALU result leaving stage 0 this cycle.
- mem_result  in  DATA_W  load data leaving stage LOAD_STAGE this cycle.
- fwd_data  out  NUM_RD*DATA_W  resolved operand per port.
- fwd_hit  out  NUM_RD  operand came from the scoreboard, not rf_data.
- stall_out  out  1  load-use hazard; decode must hold.
- wb_we  out  1  register-file write enable.
- wb_dst  out  REG_AW  register-file write address.
- wb_data  out  DATA_W  register-file write data.

Behaviour:
- Entry format: each entry k holds vld, we, load, dst, data. On reset all fields clear, so wb_we=0, wb_dst=0, wb_data=0, stall_out=0, fwd_hit=0, and fwd_data equals rf_data (0 for address 0).
- Effective data of entry k:
  - k=0 and not load: ex_result.
  - k=LOAD_STAGE and load: mem_result.
  - Otherwise: the stored data.
- Readiness: entry k is not ready iff load && k<LOAD_STAGE. All other entries are ready.
- Lookup, per port i, purely combinational:
  - If rs_addr_i==0: fwd_data=0, fwd_hit=0.
  - Otherwise, find the lowest-k (youngest) entry with vld&we&dst==rs_addr_i.
  - If that entry is ready: fwd_data is its effective data, fwd_hit=1.
  - If none matches: fwd_data=rf_data_i, fwd_hit=0.
  - An older matching entry never overrides a younger one.
- stall_out = OR over ports of "youngest match not ready". It is asserted even while hold=1.
- Advance, on a clock edge with hold=0:
  - e[k] ← e[k-1] for k≥1.
  - When e[0] moves to e[1] and is not a load, data ← ex_result.
  - When e[LOAD_STAGE] moves on and is a load, data ← mem_result.
  - All other moves keep data unchanged.
  - e[0] ← the issued instruction if iss_valid & ~stall_out & ~flush; otherwise a bubble (vld=0).
- hold=1: all entries are frozen and the flush/issue inputs are ignored that cycle. Upstream must keep flush asserted until hold deasserts.
- Writeback: wb_we=e[DEPTH-1].vld&we&(dst≠0), with wb_dst and wb_data taken from e[DEPTH-1], combinational from registers. The WB entry remains forwardable in that same cycle, covering read-during-write.
- Write to register 0: it is tracked, never matches a lookup, and never writes back.
- Latency: a non-load result is forwardable from the cycle after issue, with 0 stall cycles. A load stalls a dependent instruction for LOAD_STAGE cycles.
- Simultaneous flush and stall_out: a bubble is inserted and the flushed instruction is dropped.
- Reset asserted mid-operation: all in-flight entries are discarded immediately and no writeback occurs.

Test Plan:
- Back-to-back ALU dependency: issue r3←ALU (ex_result=0x11) then rs_addr0=3 → fwd_data0=0x11, fwd_hit0=1, stall_out=0. Two cycles later wb_we=1, wb_dst=3, wb_data=0x11.
- Load-use: issue load r5, next cycle rs_addr1=5 → stall_out=1 for exactly 1 cycle (LOAD_STAGE=1). The next cycle mem_result=0xCAFE gives fwd_data1=0xCAFE, stall_out=0, and the dependent instruction enters e[0].
- Youngest wins: issue r7←0xA then r7←0xB, read r7 → 0xB. After the second retires, rf_data feeds the read and fwd_hit=0.
- Register zero: issue r0←0xFFFF, read r0 on both ports → fwd_data=0, fwd_hit=0, and wb_we stays 0 at WB.
- Hold and flush:
  - hold=1 for 3 cycles with entries in flight → wb_* outputs are constant and stall_out is unchanged.
  - flush=1 with iss_valid=1 → a bubble enters e[0] and no wb_we pulse follows DEPTH cycles later.
- Async reset mid-stream: drop rst_n between clock edges with 3 valid entries → wb_we=0 and stall_out=0 immediately. After release, no stale forwarding occurs.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: shift-register scoreboard of in-flight writes that
// feeds operand bypass, the load-use stall and the register-file write port.
module fwd_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     iss_valid,
  input  logic                     iss_we,
  input  logic                     iss_load,
  input  logic [REG_AW-1:0]        iss_dst,
  input  logic [NUM_RD*REG_AW-1:0] rs_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0]        ex_result,
  input  logic [DATA_W-1:0]        mem_result,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic                     stall_out,
  output logic                     wb_we,
  output logic [REG_AW-1:0]        wb_dst,
  output logic [DATA_W-1:0]        wb_data
);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  we;
  logic [DEPTH-1:0]  ld;
  logic [REG_AW-1:0] dst  [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [DATA_W-1:0] eff  [DEPTH];
  logic [DEPTH-1:0]  rdy;
  logic [NUM_RD-1:0] pend;
  logic [REG_AW-1:0] addr;
  logic              issue;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      eff[k] = data[k];
      if (k == 0 && !ld[k])
        eff[k] = ex_result;
      if (k == LOAD_STAGE && ld[k])
        eff[k] = mem_result;
      rdy[k] = !(ld[k] && (k < LOAD_STAGE));
    end
  end

  // Scan oldest to youngest so the youngest match is the last to assign.
  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = '0;
    pend     = '0;
    addr     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr = rs_addr[i*REG_AW +: REG_AW];
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (vld[k] && we[k] && dst[k] == addr) begin
          fwd_data[i*DATA_W +: DATA_W] = eff[k];
          fwd_hit[i] = rdy[k];
          pend[i]    = !rdy[k];
        end
      end
      if (addr == '0) begin
        fwd_data[i*DATA_W +: DATA_W] = '0;
        fwd_hit[i] = 1'b0;
        pend[i]    = 1'b0;
      end
    end
  end

  assign stall_out = |pend;
  assign issue     = iss_valid & ~stall_out & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      we  <= '0;
      ld  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst[k]  <= '0;
        data[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        vld[k]  <= vld[k-1];
        we[k]   <= we[k-1];
        ld[k]   <= ld[k-1];
        dst[k]  <= dst[k-1];
        data[k] <= eff[k-1];
      end
      vld[0]  <= issue;
      we[0]   <= issue & iss_we;
      ld[0]   <= issue & iss_load;
      dst[0]  <= issue ? iss_dst : '0;
      data[0] <= '0;
    end
  end

  assign wb_we   = vld[DEPTH-1] & we[DEPTH-1] & (dst[DEPTH-1] != '0);
  assign wb_dst  = dst[DEPTH-1];
  assign wb_data = data[DEPTH-1];

endmodule
